ram8_arbiter: RTL and testbench

- Arbitrates two requesters (CPU port 0, loader/debug port 1) onto one shared 8-word register bank built from clocked DFF storage.
- Grants at most one access per cycle, round-robin fair, valid/ready request handshake, registered read response.
- Sits between the CPU/loader and the bank. Owns the bank's load-enable, address and write-data sequencing.

---
 rtl/ram_arb_pkg.sv | 22 ++
 rtl/ram8_bank.sv | 56 +++++
 rtl/ram8_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_ram8_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// ram_arb_pkg
// Shared definitions for the two-port register-bank arbiter:
//   - default bank geometry (word width, depth, address width)
//   - default maximum run of locked grants
//   - lock FSM state encoding (IDLE, LOCK0, LOCK1)
// Optional feature macro used by the design: ARB_LOCK_EN
// ----------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_MAX_LOCK = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_e;

endpackage : ram_arb_pkg

// File: rtl/ram8_bank.sv
// ----------------------------------------------------------------------------
// ram8_bank
// DEPTH x WIDTH register bank built from individual DFFs, each with its own
// load mux. Writes take effect at the rising edge where load = 1; reads are
// combinational, so a word written at edge k is visible right after edge k.
// Ports:
//   CLK   in   rising-edge clock
//   RST_N in   asynchronous active-low reset, clears every word to 0
//   load  in   write enable for the word selected by addr
//   addr  in   word address (ADDR_W bits)
//   din   in   write data (WIDTH bits)
//   dout  out  combinational read of the word selected by addr
// ----------------------------------------------------------------------------
module ram8_bank
  import ram_arb_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  logic [WIDTH-1:0] words [DEPTH];

  genvar gi, gb;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_word
      logic word_sel;
      assign word_sel = load && (addr == ADDR_W'(gi));

      for (gb = 0; gb < WIDTH; gb++) begin : g_bit
        logic bit_q;

        // Load mux in front of every storage bit: recirculate unless selected.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) begin
            bit_q <= 1'b0;
          end else begin
            bit_q <= word_sel ? din[gb] : bit_q;
          end
        end

        assign words[gi][gb] = bit_q;
      end
    end
  endgenerate

  assign dout = words[addr];

endmodule : ram8_bank

// File: rtl/ram8_arbiter.sv
// ----------------------------------------------------------------------------
// ram8_arbiter
// Round-robin arbiter granting at most one access per cycle from two
// requesters (port 0 = CPU, port 1 = loader/debug) onto a shared ram8_bank.
// Reads return data one cycle after acceptance via registered responses.
// Optional feature macro: ARB_LOCK_EN -- when defined, a requester can hold
// the bank for up to MAX_LOCK consecutive grants using its lock input; when
// undefined the lock inputs are ignored and arbitration is pure round-robin.
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake (ready is combinational)
//   reqN_we/addr/wdata/lock     request attributes, held stable until ready
//   rspN_valid/rdata            one-cycle read response pulse / held data
//   busy_owner                  port that won the most recent grant
// ----------------------------------------------------------------------------
module ram8_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [WIDTH-1:0]  req0_wdata,
  input  logic              req0_lock,
  output logic              rsp0_valid,
  output logic [WIDTH-1:0]  rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [WIDTH-1:0]  req1_wdata,
  input  logic              req1_lock,
  output logic              rsp1_valid,
  output logic [WIDTH-1:0]  rsp1_rdata,
  output logic              busy_owner
);

  // rr_q names the port preferred when both request (0 -> port 0 first).
  logic             rr_q, rr_d;
  logic             busy_q, busy_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [WIDTH-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic              elig0, elig1;
  logic              gnt0, gnt1, xfer;
  logic              bank_load;
  logic [ADDR_W-1:0] bank_addr;
  logic [WIDTH-1:0]  bank_din, bank_dout;

`ifdef ARB_LOCK_EN
  localparam int LCNT_W = $clog2(MAX_LOCK + 1);

  lock_state_e       lock_state_q, lock_state_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
`else
  // Lock inputs and MAX_LOCK have no function without the lock feature.
  logic unused_lock;
  assign unused_lock = req0_lock ^ req1_lock ^ (MAX_LOCK > 0);
`endif

  // --------------------------------------------------------------------------
  // Grant selection. Ready is forced low while reset is asserted so no
  // handshake can complete during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    elig0 = req0_valid;
    elig1 = req1_valid;
`ifdef ARB_LOCK_EN
    // While locked, the other port is shut out even if the owner is idle.
    if (lock_state_q == LOCK0) elig1 = 1'b0;
    if (lock_state_q == LOCK1) elig0 = 1'b0;
`endif
    gnt0 = RST_N && elig0 && (!elig1 || !rr_q);
    gnt1 = RST_N && elig1 && !gnt0;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;

  // --------------------------------------------------------------------------
  // Bank sequencing and next-state for arbitration / response registers.
  // --------------------------------------------------------------------------
  always_comb begin
    bank_addr = gnt1 ? req1_addr  : req0_addr;
    bank_din  = gnt1 ? req1_wdata : req0_wdata;
    bank_load = (gnt0 && req0_we) || (gnt1 && req1_we);

    // After any transfer the other port becomes preferred; this also yields
    // the forced hand-over when a lock run expires.
    rr_d   = xfer ? gnt0 : rr_q;
    busy_d = xfer ? gnt1 : busy_q;

    rsp0_valid_d = gnt0 && !req0_we;
    rsp1_valid_d = gnt1 && !req1_we;
    rsp0_rdata_d = rsp0_valid_d ? bank_dout : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? bank_dout : rsp1_rdata_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_q         <= 1'b0;
      busy_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rr_q         <= rr_d;
      busy_q       <= busy_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

`ifdef ARB_LOCK_EN
  // --------------------------------------------------------------------------
  // Lock FSM. lcnt counts grants in the current locked run, including the
  // grant that entered the lock, so a run is at most MAX_LOCK grants long.
  // --------------------------------------------------------------------------
  always_comb begin
    lock_state_d = lock_state_q;
    lcnt_d       = lcnt_q;
    case (lock_state_q)
      IDLE: begin
        // With MAX_LOCK <= 1 the entering grant already exhausts the run.
        if (gnt0 && req0_lock && (MAX_LOCK > 1)) begin
          lock_state_d = LOCK0;
          lcnt_d       = LCNT_W'(1);
        end else if (gnt1 && req1_lock && (MAX_LOCK > 1)) begin
          lock_state_d = LOCK1;
          lcnt_d       = LCNT_W'(1);
        end
      end
      LOCK0: begin
        if (gnt0) begin
          if (!req0_lock || (lcnt_q == LCNT_W'(MAX_LOCK - 1))) begin
            lock_state_d = IDLE;
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end
      end
      LOCK1: begin
        if (gnt1) begin
          if (!req1_lock || (lcnt_q == LCNT_W'(MAX_LOCK - 1))) begin
            lock_state_d = IDLE;
          end else begin
            lcnt_d = lcnt_q + LCNT_W'(1);
          end
        end
      end
      default: lock_state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lock_state_q <= IDLE;
      lcnt_q       <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lcnt_q       <= lcnt_d;
    end
  end
`endif

  ram8_bank #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_bank (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (bank_load),
    .addr  (bank_addr),
    .din   (bank_din),
    .dout  (bank_dout)
  );

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign busy_owner = busy_q;

endmodule : ram8_arbiter

// File: tb/tb_ram8_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram8_arbiter
// Directed stimulus for ram8_arbiter with a scoreboard: each accepted read
// pushes its expected data and due cycle; a monitor on the falling edge pops
// and compares whenever a response is due, and otherwise expects rsp idle.
// ----------------------------------------------------------------------------
module tb_ram8_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req0_valid, req0_ready, req0_we, req0_lock;
  logic [2:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        rsp0_valid;
  logic [15:0] rsp0_rdata;
  logic        req1_valid, req1_ready, req1_we, req1_lock;
  logic [2:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp1_valid;
  logic [15:0] rsp1_rdata;
  logic        busy_owner;

  always #5 CLK = ~CLK;

  ram8_arbiter dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req0_lock  (req0_lock),
    .rsp0_valid (rsp0_valid),
    .rsp0_rdata (rsp0_rdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .req1_lock  (req1_lock),
    .rsp1_valid (rsp1_valid),
    .rsp1_rdata (rsp1_rdata),
    .busy_owner (busy_owner)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] mdl [8];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Response monitor
  initial begin
    forever begin
      @(negedge CLK);
      if (q0.size() > 0 && q0[0].due == cyc) begin
        check("rsp0_valid", rsp0_valid, 1);
        check("rsp0_rdata", rsp0_rdata, q0[0].data);
        void'(q0.pop_front());
      end else begin
        check("rsp0_idle", rsp0_valid, 0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
        check("rsp1_valid", rsp1_valid, 1);
        check("rsp1_rdata", rsp1_rdata, q1[0].data);
        void'(q1.pop_front());
      end else begin
        check("rsp1_idle", rsp1_valid, 0);
      end
    end
  end

  task automatic drv0(input logic v, input logic we, input logic [2:0] a,
                      input logic [15:0] d, input logic l);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d; req0_lock = l;
  endtask

  task automatic drv1(input logic v, input logic we, input logic [2:0] a,
                      input logic [15:0] d, input logic l);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d; req1_lock = l;
  endtask

  // Called at posedge+1 with inputs driven; returns at the next posedge+1.
  task automatic step(input logic er0, input logic er1, input string nm);
    #2;
    check({nm, ".ready0"}, req0_ready, er0);
    check({nm, ".ready1"}, req1_ready, er1);
    if (er0 && req0_valid) begin
      if (!req0_we) q0.push_back('{cyc + 1, mdl[req0_addr]});
      else mdl[req0_addr] = req0_wdata;
      $display("txn %s port0 %s addr=%0d data=%h", nm, req0_we ? "wr" : "rd",
               req0_addr, req0_we ? req0_wdata : mdl[req0_addr]);
    end
    if (er1 && req1_valid) begin
      if (!req1_we) q1.push_back('{cyc + 1, mdl[req1_addr]});
      else mdl[req1_addr] = req1_wdata;
      $display("txn %s port1 %s addr=%0d data=%h", nm, req1_we ? "wr" : "rd",
               req1_addr, req1_we ? req1_wdata : mdl[req1_addr]);
    end
    @(posedge CLK);
    #1;
    if (er0 || er1) check({nm, ".busy_owner"}, busy_owner, er1);
  endtask

  logic [5:0] lk0, lk1;

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    // Requests asserted during reset must not be accepted.
    drv0(1, 1, 3'd7, 16'hdead, 0);
    drv1(1, 1, 3'd6, 16'hbeef, 0);
    #3;
    check("rst.ready0", req0_ready, 0);
    check("rst.ready1", req1_ready, 0);
    check("rst.rsp0_rdata", rsp0_rdata, 0);
    check("rst.rsp1_rdata", rsp1_rdata, 0);
    check("rst.busy_owner", busy_owner, 0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Port 0 writes, port 1 reads it back.
    drv0(1, 1, 3'd3, 16'h1234, 0);
    drv1(0, 0, 3'd0, 16'h0000, 0);
    step(1, 0, "t1_wr");
    drv0(0, 0, 3'd0, 16'h0000, 0);
    drv1(1, 0, 3'd3, 16'h0000, 0);
    step(0, 1, "t1_rd");

    // Both ports reading: grants alternate 0,1,0,1.
    drv0(1, 0, 3'd3, 16'h0000, 0);
    drv1(1, 0, 3'd0, 16'h0000, 0);
    for (int i = 0; i < 4; i++) step(i % 2 == 0, i % 2 == 1, "t2_rr");

    // Port 0 fills the bank with addr*0x1111, then streams reads back.
    drv1(0, 0, 3'd0, 16'h0000, 0);
    for (int i = 0; i < 8; i++) begin
      drv0(1, 1, 3'(i), 16'(i * 16'h1111), 0);
      step(1, 0, "t3_wr");
    end
    for (int i = 0; i < 8; i++) begin
      drv0(1, 0, 3'(i), 16'h0000, 0);
      step(1, 0, "t3_rd");
    end

    // Read accepted, then reset before the response edge: response dropped.
    drv0(0, 0, 3'd0, 16'h0000, 0);
    drv1(1, 0, 3'd5, 16'h0000, 0);
    step(0, 1, "t4_rd");
    RST_N = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    drv1(0, 0, 3'd0, 16'h0000, 0);
    #2;
    check("t4.rsp1_valid", rsp1_valid, 0);
    check("t4.rsp1_rdata", rsp1_rdata, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    drv1(1, 0, 3'd5, 16'h0000, 0);
    step(0, 1, "t4_rd0");

    // Port 1 requests with lock held while port 0 stays valid.
`ifdef ARB_LOCK_EN
    lk0 = 6'b100001;
    lk1 = 6'b011110;
`else
    lk0 = 6'b010101;
    lk1 = 6'b101010;
`endif
    drv0(1, 0, 3'd1, 16'h0000, 0);
    drv1(1, 0, 3'd2, 16'h0000, 1);
    for (int i = 0; i < 6; i++) step(lk0[i], lk1[i], "t5_lock");

    drv0(0, 0, 3'd0, 16'h0000, 0);
    drv1(0, 0, 3'd0, 16'h0000, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("end.q0_empty", q0.size(), 0);
    check("end.q1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram8_arbiter
